// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: FETCH -> WAIT -> VALID with redirect/drain handling.
// Optional macro IFU_MISALIGN_TRAP_EN adds a sticky misalign_err output and a HALT state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [6:0]  Op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  output logic [2:0]  dbg_state
);

`ifdef IFU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {FETCH, WAIT, DRAIN, VALID, HALT} state_t;
`else
  typedef enum logic [2:0] {FETCH, WAIT, DRAIN, VALID} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] dpc_q, dpc_d;
  logic [31:0] redirect_tgt;
  logic        redirect_eff;

`ifdef IFU_MISALIGN_TRAP_EN
  logic err_q, err_d;
  assign redirect_tgt = redirect_pc;
  assign redirect_eff = redirect && (state_q != HALT);
  assign misalign_err = err_q;
`else
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign redirect_eff = redirect;
`endif

  // Decoder handshake: dec_valid holds the word until a cycle with dec_valid && dec_ready
  // consumes it; dec_instr/dec_pc never change while dec_valid is high and no redirect occurs.
  assign imem_req  = (state_q == FETCH) && !redirect && !rst;
  assign imem_addr = pc_q;
  assign dec_valid = (state_q == VALID);
  assign dec_instr = instr_q;
  assign dec_pc    = dpc_q;
  assign Op        = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign funct7    = instr_q[31:25];
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    dpc_d   = dpc_q;
`ifdef IFU_MISALIGN_TRAP_EN
    err_d   = err_q;
`endif
    if (redirect_eff) begin
      pc_d = redirect_tgt;
      case (state_q)
        WAIT:    state_d = imem_rvalid ? FETCH : DRAIN;
        // A response landing together with the redirect still completes the drain.
        DRAIN:   state_d = imem_rvalid ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
`ifdef IFU_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        err_d   = 1'b1;
        state_d = HALT;
      end
`endif
    end else begin
      case (state_q)
        FETCH: state_d = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            dpc_d   = pc_q;
            state_d = VALID;
          end
        end
        DRAIN: begin
          if (imem_rvalid) state_d = FETCH;
        end
        VALID: begin
          if (dec_ready) begin
            pc_d    = pc_q + 32'd4;
            state_d = FETCH;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0013;
      dpc_q   <= RESET_PC;
`ifdef IFU_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      dpc_q   <= dpc_d;
`ifdef IFU_MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model (one fetch slot, one held-instruction queue).
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  dbg_state;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc),
    .Op(op), .funct3(funct3), .funct7(funct7),
    .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef IFU_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .dbg_state(dbg_state)
  );

  // Advance one clock; inputs return to idle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    dec_ready   = 1'b0;
    imem_rdata  = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    #1;
    tests++; if (imem_req !== 1'b0) begin $display("FAIL rst_req: got %b want 0", imem_req); fails++; end
    cyc();
    rst = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b1) begin $display("FAIL first_req: got %b want 1", imem_req); fails++; end
    tests++; if (imem_addr !== RST_PC) begin $display("FAIL first_addr: got %h want %h", imem_addr, RST_PC); fails++; end
    tests++; if (dec_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", dec_valid); fails++; end
    tests++; if (dec_instr !== NOP) begin $display("FAIL rst_instr: got %h want %h", dec_instr, NOP); fails++; end
    tests++; if (dec_pc !== RST_PC) begin $display("FAIL rst_pc: got %h want %h", dec_pc, RST_PC); fails++; end
  endtask

  task automatic test_first_fetch();
    cyc();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    #1;
    tests++; if (dec_valid !== 1'b0 || imem_req !== 1'b0) begin $display("FAIL wait_cycle: valid=%b req=%b want 0/0", dec_valid, imem_req); fails++; end
    cyc();
    #1;
    tests++; if (dec_valid !== 1'b1) begin $display("FAIL c3_valid: got %b want 1", dec_valid); fails++; end
    tests++; if (op !== 7'h13 || funct3 !== 3'd0 || funct7 !== 7'd0) begin $display("FAIL c3_fields: op=%h f3=%h f7=%h want 13/0/0", op, funct3, funct7); fails++; end
    tests++; if (dec_instr !== 32'h0050_0093 || dec_pc !== RST_PC) begin $display("FAIL c3_word: instr=%h pc=%h want 00500093/%h", dec_instr, dec_pc, RST_PC); fails++; end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (dec_valid !== 1'b1 || imem_req !== 1'b0 || dec_instr !== 32'h0050_0093 || dec_pc !== RST_PC) begin
        $display("FAIL stall_%0d: valid=%b req=%b instr=%h pc=%h want 1/0/00500093/%h", i, dec_valid, imem_req, dec_instr, dec_pc, RST_PC);
        fails++;
      end
      cyc();
    end
    dec_ready = 1'b1;
    cyc();
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin $display("FAIL after_stall: req=%b addr=%h want 1/00000104", imem_req, imem_addr); fails++; end
  endtask

  task automatic test_redirect_wait();
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    #1;
    tests++; if (imem_req !== 1'b0) begin $display("FAIL rdw_req: got %b want 0", imem_req); fails++; end
    cyc();
    #1;
    tests++; if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin $display("FAIL drain_idle: req=%b valid=%b want 0/0", imem_req, dec_valid); fails++; end
    cyc();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    tests++; if (imem_req !== 1'b0) begin $display("FAIL drain_resp_req: got %b want 0", imem_req); fails++; end
    cyc();
    #1;
    tests++; if (dec_valid !== 1'b0) begin $display("FAIL drain_drop: valid=%b want 0", dec_valid); fails++; end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin $display("FAIL rdw_next: req=%b addr=%h want 1/00000200", imem_req, imem_addr); fails++; end
  endtask

  task automatic test_same_cycle();
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    #1;
    cyc();
    #1;
    tests++; if (dec_valid !== 1'b0) begin $display("FAIL same_valid: got %b want 0", dec_valid); fails++; end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin $display("FAIL same_next: req=%b addr=%h want 1/00000300", imem_req, imem_addr); fails++; end
  endtask

  task automatic test_wrap();
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    imem_rvalid = 1'b1;
    cyc();
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin $display("FAIL wrap_req: req=%b addr=%h want 1/fffffffc", imem_req, imem_addr); fails++; end
    cyc();
    imem_rvalid = 1'b1;
    imem_rdata  = NOP;
    cyc();
    #1;
    tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'hFFFF_FFFC) begin $display("FAIL wrap_hold: valid=%b pc=%h want 1/fffffffc", dec_valid, dec_pc); fails++; end
    dec_ready = 1'b1;
    cyc();
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin $display("FAIL wrap_next: req=%b addr=%h want 1/00000000", imem_req, imem_addr); fails++; end
  endtask

  task automatic test_misalign();
    redirect    = 1'b1;
    redirect_pc = 32'h202;
    #1;
    tests++; if (imem_req !== 1'b0) begin $display("FAIL mis_req: got %b want 0", imem_req); fails++; end
    cyc();
    #1;
`ifdef IFU_MISALIGN_TRAP_EN
    tests++; if (misalign_err !== 1'b1) begin $display("FAIL mis_err: got %b want 1", misalign_err); fails++; end
    for (int i = 0; i < 4; i++) begin
      cyc();
      redirect    = i[0];
      redirect_pc = 32'h400;
      #1;
      tests++;
      if (imem_req !== 1'b0 || dec_valid !== 1'b0 || misalign_err !== 1'b1) begin
        $display("FAIL halt_%0d: req=%b valid=%b err=%b want 0/0/1", i, imem_req, dec_valid, misalign_err);
        fails++;
      end
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    tests++; if (misalign_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin $display("FAIL halt_exit: err=%b req=%b addr=%h want 0/1/%h", misalign_err, imem_req, imem_addr, RST_PC); fails++; end
`else
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin $display("FAIL mis_forced: req=%b addr=%h want 1/00000200", imem_req, imem_addr); fails++; end
`endif
  endtask

  // Random traffic: memory with 1..3 cycle latency, random redirects, stalls and resets.
  task automatic test_random();
    logic [31:0] m_pc = RST_PC;
    logic        m_busy = 1'b0;
    logic        m_stale = 1'b0;
    logic        exp_req;
    logic        mem_pending = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_data = '0;
    logic [63:0] head;
    for (int cyc_i = 0; cyc_i < 4000; cyc_i++) begin
      cyc();
      rst = (cyc_i == 0) || ($urandom_range(0, 63) == 0);
      if (mem_pending) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_data;
          mem_pending = 1'b0;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        imem_rvalid = 1'b1;
      end
      redirect = ($urandom_range(0, 7) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
`ifdef IFU_MISALIGN_TRAP_EN
      redirect_pc[1:0] = 2'b00;
`endif
      dec_ready = 1'($urandom_range(0, 1));
      #1;
      exp_req = !rst && !redirect && !m_busy && !m_stale && (exp_q.size() == 0);
      tests++; if (imem_req !== exp_req) begin $display("FAIL rnd_req c%0d: got %b want %b", cyc_i, imem_req, exp_req); fails++; end
      if (exp_req) begin
        tests++; if (imem_addr !== m_pc) begin $display("FAIL rnd_addr c%0d: got %h want %h", cyc_i, imem_addr, m_pc); fails++; end
      end
      if (!rst) begin
        tests++; if (dec_valid !== (exp_q.size() != 0)) begin $display("FAIL rnd_valid c%0d: got %b want %b", cyc_i, dec_valid, exp_q.size() != 0); fails++; end
        if (exp_q.size() != 0) begin
          head = exp_q[0];
          tests++;
          if ({dec_pc, dec_instr} !== head || op !== head[6:0] || funct3 !== head[14:12] || funct7 !== head[31:25]) begin
            $display("FAIL rnd_word c%0d: pc=%h instr=%h want pc=%h instr=%h", cyc_i, dec_pc, dec_instr, head[63:32], head[31:0]);
            fails++;
          end
        end
      end
      if (imem_req === 1'b1) begin
        mem_pending = 1'b1;
        mem_cnt     = $urandom_range(1, 3);
        mem_data    = $urandom;
      end
      if (rst) begin
        m_pc = RST_PC; m_busy = 1'b0; m_stale = 1'b0;
        exp_q.delete();
      end else if (redirect) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        if (m_busy) begin
          m_stale = !imem_rvalid;
          m_busy  = 1'b0;
        end else if (m_stale && imem_rvalid) begin
          m_stale = 1'b0;
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (exp_req) begin
        m_busy = 1'b1;
      end else if (m_busy && imem_rvalid) begin
        exp_q.push_back({m_pc, imem_rdata});
        m_busy = 1'b0;
      end else if (m_stale && imem_rvalid) begin
        m_stale = 1'b0;
      end else if (exp_q.size() != 0 && dec_ready) begin
        void'(exp_q.pop_front());
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    dec_ready   = 1'b0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_same_cycle();
    test_wrap();
    test_misalign();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
